// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle RV32I control unit: fetches over a valid/request handshake, decodes
// into ALU/branch/immediate controls and sequences memory access, writeback and PC update.
module rv_ctrl_fsm #(
  parameter int DATA_W = 32,
  parameter int OPW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  output logic              instr_req,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic [OPW-1:0]    alu_op,
  output logic              alu_input_select,
  output logic              branch,
  output logic [2:0]        funct3,
  input  logic              pc_select,
  output logic [DATA_W-1:0] imm,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready,
  output logic              wb_from_mem,
  output logic              pc_write,
  output logic              pc_taken,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    K_ALU,
    K_LOAD,
    K_STORE,
    K_BRANCH
  } kind_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_e              state_q, state_d;
  kind_e               kind_q, kind_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [OPW-1:0]      alu_op_q, alu_op_d;
  logic                alu_sel_q, alu_sel_d;
  logic                branch_q, branch_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [4:0]          rs1_q, rs1_d;
  logic [4:0]          rs2_q, rs2_d;
  logic [4:0]          rd_q, rd_d;
  logic                reg_write_q, reg_write_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                wb_from_mem_q, wb_from_mem_d;
  logic                pc_write_q, pc_write_d;
  logic                instr_req_q, instr_req_d;
  logic                illegal_q, illegal_d;

  logic [6:0]          opcode;
  logic [2:0]          f3;
  logic [DATA_W-1:0]   imm_i, imm_s, imm_b;
  logic                store_done;

  assign opcode = ir_q[6:0];
  assign f3     = ir_q[14:12];
  assign imm_i  = {{(DATA_W-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{(DATA_W-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{(DATA_W-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  always_comb begin
    // NOTE: every _d starts from a default so no path through the case leaves it unassigned (no latches).
    state_d       = state_q;
    kind_d        = kind_q;
    ir_d          = ir_q;
    alu_op_d      = alu_op_q;
    alu_sel_d     = alu_sel_q;
    branch_d      = 1'b0;
    funct3_d      = funct3_q;
    imm_d         = imm_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    reg_write_d   = 1'b0;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    wb_from_mem_d = 1'b0;
    pc_write_d    = 1'b0;
    illegal_d     = illegal_q;

    unique case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        rs1_d     = ir_q[19:15];
        rs2_d     = ir_q[24:20];
        rd_d      = ir_q[11:7];
        funct3_d  = f3;
        imm_d     = imm_i;
        alu_op_d  = '0;
        alu_sel_d = 1'b1;
        kind_d    = K_ALU;
        state_d   = S_EXECUTE;
        case (opcode)
          OPC_OP: begin
            alu_op_d  = {ir_q[30], f3, 1'b0, 1'b1};
            alu_sel_d = 1'b0;
          end
          OPC_OP_IMM: begin
            // Only the shift-right pair uses bit 30 to pick arithmetic vs logical.
            alu_op_d = {(f3 == 3'b101) & ir_q[30], f3, 2'b00};
          end
          OPC_LOAD: begin
            kind_d = K_LOAD;
            if (f3 != 3'b010) state_d = S_HALT;
          end
          OPC_STORE: begin
            kind_d = K_STORE;
            imm_d  = imm_s;
            if (f3 != 3'b010) state_d = S_HALT;
          end
          OPC_BRANCH: begin
            kind_d     = K_BRANCH;
            imm_d      = imm_b;
            alu_sel_d  = 1'b0;
            branch_d   = 1'b1;
            pc_write_d = 1'b1;
            case (f3[2:1])
              2'b00:   alu_op_d = 6'b100001;
              2'b10:   alu_op_d = 6'b001000;
              2'b11:   alu_op_d = 6'b001100;
              default: state_d  = S_HALT;
            endcase
          end
          default: state_d = S_HALT;
        endcase
        if (state_d == S_HALT) begin
          illegal_d  = 1'b1;
          branch_d   = 1'b0;
          pc_write_d = 1'b0;
        end
      end

      S_EXECUTE: begin
        unique case (kind_q)
          K_ALU: begin
            state_d     = S_WB;
            reg_write_d = (rd_q != 5'd0);
            pc_write_d  = 1'b1;
          end
          K_LOAD: begin
            state_d    = S_MEM;
            mem_read_d = 1'b1;
          end
          K_STORE: begin
            state_d     = S_MEM;
            mem_write_d = 1'b1;
          end
          K_BRANCH: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (kind_q == K_LOAD) begin
            state_d       = S_WB;
            reg_write_d   = (rd_q != 5'd0);
            wb_from_mem_d = 1'b1;
            pc_write_d    = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_WB:   state_d = S_FETCH;

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase

    instr_req_d = (state_d == S_FETCH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      kind_q        <= K_ALU;
      ir_q          <= '0;
      alu_op_q      <= '0;
      alu_sel_q     <= 1'b0;
      branch_q      <= 1'b0;
      funct3_q      <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      wb_from_mem_q <= 1'b0;
      pc_write_q    <= 1'b0;
      instr_req_q   <= 1'b1;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      ir_q          <= ir_d;
      alu_op_q      <= alu_op_d;
      alu_sel_q     <= alu_sel_d;
      branch_q      <= branch_d;
      funct3_q      <= funct3_d;
      imm_q         <= imm_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      wb_from_mem_q <= wb_from_mem_d;
      pc_write_q    <= pc_write_d;
      instr_req_q   <= instr_req_d;
      illegal_q     <= illegal_d;
    end
  end

  // Store retirement and branch direction depend on same-cycle inputs, so those two terms stay combinational.
  assign store_done = (state_q == S_MEM) && (kind_q == K_STORE) && mem_ready && !reset;

  assign instr_req        = instr_req_q;
  assign alu_op           = alu_op_q;
  assign alu_input_select = alu_sel_q;
  assign branch           = branch_q;
  assign funct3           = funct3_q;
  assign imm              = imm_q;
  assign rs1              = rs1_q;
  assign rs2              = rs2_q;
  assign rd               = rd_q;
  assign reg_write        = reg_write_q;
  assign mem_read         = mem_read_q;
  assign mem_write        = mem_write_q;
  assign wb_from_mem      = wb_from_mem_q;
  assign pc_write         = pc_write_q | store_done;
  assign pc_taken         = pc_write_q & branch_q & pc_select;
  assign illegal          = illegal_q;

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Self-checking bench for rv_ctrl_fsm: a vector table run through a scoreboard queue,
// plus hand-written sequences for halt, idle fetch and reset during a memory access.
module tb_rv_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic        instr_req;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  alu_op;
  logic        alu_input_select;
  logic        branch;
  logic [2:0]  funct3;
  logic        pc_select;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, mem_read, mem_write, mem_ready;
  logic        wb_from_mem, pc_write, pc_taken, illegal;

  rv_ctrl_fsm #(.DATA_W(32), .OPW(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_req        (instr_req),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .alu_op           (alu_op),
    .alu_input_select (alu_input_select),
    .branch           (branch),
    .funct3           (funct3),
    .pc_select        (pc_select),
    .imm              (imm),
    .rs1              (rs1),
    .rs2              (rs2),
    .rd               (rd),
    .reg_write        (reg_write),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_ready        (mem_ready),
    .wb_from_mem      (wb_from_mem),
    .pc_write         (pc_write),
    .pc_taken         (pc_taken),
    .illegal          (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        pc_sel;
    logic        noise;
    int          mem_wait;
    logic        chk_imm;
    logic [5:0]  alu_op;
    logic        sel;
    logic        br;
    logic [31:0] imm;
    int          lat;
    logic        regw;
    logic        wbm;
    logic        taken;
    int          mrd;
    int          mwr;
    logic        ill;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  vec_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic ps, input logic nz, input int mw,
                              input logic ci, input logic [5:0] op, input logic sel, input logic br,
                              input logic [31:0] im, input int lat, input logic rw, input logic wbm,
                              input logic tk, input int mrd, input int mwr, input logic ill);
    vec_t v;
    v.instr = i;  v.pc_sel = ps; v.noise = nz; v.mem_wait = mw; v.chk_imm = ci;
    v.alu_op = op; v.sel = sel;  v.br = br;    v.imm = im;      v.lat = lat;
    v.regw = rw;  v.wbm = wbm;   v.taken = tk; v.mrd = mrd;     v.mwr = mwr; v.ill = ill;
    return v;
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    pc_select   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drives one instruction and observes it to retirement (or to the illegal flag).
  task automatic run_vec(input vec_t v);
    vec_t        e;
    int          waited = 0;
    int          mem_cnt = 0;
    int          lat = 0, regw_n = 0, pcw_n = 0, br_n = 0, mrd_n = 0, mwr_n = 0;
    logic        wbm_seen = 1'b0, taken_seen = 1'b0, overlap = 1'b0, ill_seen = 1'b0;
    logic [5:0]  x_op = '0;
    logic        x_sel = 1'b0;
    logic [2:0]  x_f3 = '0;
    logic [31:0] x_imm = '0;
    logic [4:0]  x_rs1 = '0, x_rs2 = '0, x_rd = '0;
    bit          done = 1'b0;

    sb_q.push_back(v);
    while (!instr_req && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("fetch_wait", 32'(instr_req), 32'd1);
    instr       = v.instr;
    instr_valid = 1'b1;
    pc_select   = v.pc_sel;
    mem_ready   = v.noise;

    for (int k = 1; k <= 30 && !done; k++) begin
      @(posedge clk); #1;
      if (mem_read || mem_write) begin
        mem_ready = v.noise | (mem_cnt >= v.mem_wait);
        mem_cnt++;
      end else begin
        mem_ready = v.noise;
      end
      #1;
      if (k == 2) begin
        x_op = alu_op; x_sel = alu_input_select; x_f3 = funct3; x_imm = imm;
        x_rs1 = rs1;   x_rs2 = rs2;              x_rd = rd;
      end
      if (branch)    br_n++;
      if (mem_read)  mrd_n++;
      if (mem_write) mwr_n++;
      if (wb_from_mem) wbm_seen = 1'b1;
      if (reg_write) begin
        regw_n++;
        if (mem_read || mem_write) overlap = 1'b1;
      end
      if (pc_write) begin
        pcw_n++;
        taken_seen = pc_taken;
      end
      if (illegal) begin
        ill_seen = 1'b1;
        done     = 1'b1;
      end else if (instr_req) begin
        lat  = k;
        done = 1'b1;
      end
    end
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    pc_select   = 1'b0;

    check("sb_nonempty", 32'(sb_q.size()), 32'(1));
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();

    check("illegal", 32'(ill_seen), 32'(e.ill));
    check("pc_writes", 32'(pcw_n), e.ill ? 32'd0 : 32'd1);
    check("reg_writes", 32'(regw_n), 32'(e.regw));
    check("mem_rd_cycles", 32'(mrd_n), 32'(e.mrd));
    check("mem_wr_cycles", 32'(mwr_n), 32'(e.mwr));
    check("strobe_overlap", 32'(overlap), 32'd0);
    if (!e.ill) begin
      check("alu_op", 32'(x_op), 32'(e.alu_op));
      check("alu_sel", 32'(x_sel), 32'(e.sel));
      check("branch_cycles", 32'(br_n), e.br ? 32'd1 : 32'd0);
      check("funct3", 32'(x_f3), 32'(e.instr[14:12]));
      check("rs1", 32'(x_rs1), 32'(e.instr[19:15]));
      check("rs2", 32'(x_rs2), 32'(e.instr[24:20]));
      check("rd", 32'(x_rd), 32'(e.instr[11:7]));
      if (e.chk_imm) check("imm", x_imm, e.imm);
      check("latency", 32'(lat), 32'(e.lat));
      check("wb_from_mem", 32'(wbm_seen), 32'(e.wbm));
      check("pc_taken", 32'(taken_seen), 32'(e.taken));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int halt_bad;
    int idle_bad;
    int seen;

    instr       = '0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    pc_select   = 1'b0;
    reset       = 1'b1;

    //          instr          ps  nz  mw ci  alu_op     sel br imm            lat rw wbm tk mrd mwr ill
    vecs.push_back(mk(32'h002081B3, 1, 1, 0, 0, 6'b000001, 0, 0, 32'h0,        4, 1, 0, 0, 0, 0, 0)); // add x3,x1,x2
    vecs.push_back(mk(32'h40F55513, 0, 0, 0, 1, 6'b110100, 1, 0, 32'h0000040F, 4, 1, 0, 0, 0, 0, 0)); // srai x10,x10,15
    vecs.push_back(mk(32'h40008093, 0, 0, 0, 1, 6'b000000, 1, 0, 32'h00000400, 4, 1, 0, 0, 0, 0, 0)); // addi, bit30 set
    vecs.push_back(mk(32'hFFF00293, 0, 0, 0, 1, 6'b000000, 1, 0, 32'hFFFFFFFF, 4, 1, 0, 0, 0, 0, 0)); // addi x5,x0,-1
    vecs.push_back(mk(32'h00208033, 0, 0, 0, 0, 6'b000001, 0, 0, 32'h0,        4, 0, 0, 0, 0, 0, 0)); // add x0: no write
    vecs.push_back(mk(32'h402081B3, 0, 0, 0, 0, 6'b100001, 0, 0, 32'h0,        4, 1, 0, 0, 0, 0, 0)); // sub
    vecs.push_back(mk(32'hFE209EE3, 1, 0, 0, 1, 6'b100001, 0, 1, 32'hFFFFFFFC, 3, 0, 0, 1, 0, 0, 0)); // bne taken
    vecs.push_back(mk(32'h00208463, 0, 0, 0, 1, 6'b100001, 0, 1, 32'h00000008, 3, 0, 0, 0, 0, 0, 0)); // beq not taken
    vecs.push_back(mk(32'h0020D863, 1, 0, 0, 1, 6'b001000, 0, 1, 32'h00000010, 3, 0, 0, 1, 0, 0, 0)); // bge taken
    vecs.push_back(mk(32'hFE20EEE3, 0, 0, 0, 1, 6'b001100, 0, 1, 32'hFFFFFFFC, 3, 0, 0, 0, 0, 0, 0)); // bltu not taken
    vecs.push_back(mk(32'hFE20FEE3, 1, 0, 0, 1, 6'b001100, 0, 1, 32'hFFFFFFFC, 3, 0, 0, 1, 0, 0, 0)); // bgeu taken
    vecs.push_back(mk(32'h0040A183, 1, 0, 3, 1, 6'b000000, 1, 0, 32'h00000004, 8, 1, 1, 0, 4, 0, 0)); // lw, 3 wait
    vecs.push_back(mk(32'h0040A183, 0, 0, 0, 1, 6'b000000, 1, 0, 32'h00000004, 5, 1, 1, 0, 1, 0, 0)); // lw, no wait
    vecs.push_back(mk(32'h0020A423, 1, 0, 0, 1, 6'b000000, 1, 0, 32'h00000008, 4, 0, 0, 0, 0, 1, 0)); // sw, no wait
    vecs.push_back(mk(32'h0020A423, 0, 0, 2, 1, 6'b000000, 1, 0, 32'h00000008, 6, 0, 0, 0, 0, 3, 0)); // sw, 2 wait
    vecs.push_back(mk(32'hFE20AEE3, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1)); // branch f3=010
    vecs.push_back(mk(32'h00008183, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1)); // lb
    vecs.push_back(mk(32'h00209423, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1)); // sh
    vecs.push_back(mk(32'h0000006F, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1)); // jal

    do_reset();
    check("rst_instr_req", 32'(instr_req), 32'd1);
    check("rst_strobes", 32'({reg_write, mem_read, mem_write, pc_write, wb_from_mem, branch}), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_imm", imm, 32'd0);

    // Idle fetch: no instr_valid, mem_ready noise, nothing must move.
    idle_bad  = 0;
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (!instr_req || pc_write || reg_write || mem_read || mem_write) idle_bad++;
    end
    mem_ready = 1'b0;
    check("idle_fetch_violations", 32'(idle_bad), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
      if (vecs[i].ill) do_reset();
    end

    // Unsupported opcode: HALT holds for 20 cycles despite input activity.
    run_vec(mk(32'h0000007F, 0, 0, 0, 0, 6'b0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1));
    halt_bad    = 0;
    instr_valid = 1'b1;
    mem_ready   = 1'b1;
    pc_select   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (instr_req || pc_write || reg_write || mem_read || mem_write || branch || !illegal) halt_bad++;
    end
    check("halt_violations", 32'(halt_bad), 32'd0);
    do_reset();
    check("post_halt_illegal", 32'(illegal), 32'd0);
    check("post_halt_instr_req", 32'(instr_req), 32'd1);

    // Reset asserted while a store waits in MEM.
    instr       = 32'h0020A423;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    seen        = 0;
    for (int i = 0; i < 10 && !mem_write; i++) begin
      @(posedge clk); #1;
    end
    check("store_reached_mem", 32'(mem_write), 32'd1);
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("no_pc_write_in_reset", 32'(pc_write), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_mem_write_dropped", 32'(mem_write), 32'd0);
    check("rst_back_in_fetch", 32'(instr_req), 32'd1);
    check("rst_no_pc_write", 32'(pc_write), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      if (pc_write || mem_write || mem_read || reg_write || !instr_req) seen++;
    end
    mem_ready = 1'b0;
    check("post_rst_quiet", 32'(seen), 32'd0);

    // Machine still works after the mid-access reset.
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_ctrl_fsm.md
Name: rv_ctrl_fsm

Overview:
- Multi-cycle control unit for the RV32I datapath; it is the producer side of the ALU control interface.
- Fetches an instruction over a valid/request handshake and decodes it into the 6-bit ALU op code, operand-select, branch and funct3 controls, plus the immediate.
- Consumes the ALU's PC_select result to resolve branches.
- Sequences register writeback, data-memory access and PC update.

Parameters:
- DATA_W, 32, datapath and instruction width.
- OPW, 6, ALU op code width (matches `OPWIDTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_req  out  1  request the next instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr  in  DATA_W  fetched instruction.
- alu_op  out  OPW  ALU op code {f7b5, funct3, 1'b0, is_reg}.
- alu_input_select  out  1  0 = second operand from rs2 data, 1 = from immediate.
- branch  out  1  current EXECUTE is a conditional branch.
- funct3  out  3  instruction funct3 (branch polarity into the ALU).
- pc_select  in  1  ALU branch-taken result.
- imm  out  DATA_W  sign-extended immediate.
- rs1, rs2, rd  out  5 each  register addresses.
- reg_write  out  1  register-file write strobe.
- mem_read, mem_write  out  1 each  data-memory strobes.
- mem_ready  in  1  data-memory access complete.
- wb_from_mem  out  1  writeback mux: 1 = load data, 0 = ALU out.
- pc_write  out  1  one-cycle PC update strobe.
- pc_taken  out  1  with pc_write: 1 = PC+imm, 0 = PC+4.
- illegal  out  1  sticky unsupported-opcode flag.

Behaviour:
- Reset: state=FETCH and the instruction register clears to 0. All outputs are 0 except instr_req, which is 1 in FETCH. Reset mid-access drops any request immediately; no strobe is issued afterwards.
- States and transitions:
  - FETCH -> DECODE -> EXECUTE -> {MEM, WB, FETCH}.
  - MEM -> {WB, FETCH}; WB -> FETCH.
  - HALT is terminal until reset.
- FETCH:
  - instr_req=1 while in FETCH.
  - On instr_valid, latch instr and go to DECODE.
  - Without instr_valid, stay indefinitely.
- DECODE: register rs1/rs2/rd/funct3 and the immediate.
  - I-type immediate: instr[31:20] sign-extended.
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - Unsupported opcode -> illegal=1, go to HALT.
- EXECUTE: the ALU is combinational; alu_* are held stable for this whole cycle.
  - OP (0110011): alu_op={instr[30], f3, 0, 1}, select=0. Next state WB.
  - OP-IMM (0010011): alu_op={instr[30] if f3==101 else 0, f3, 0, 0}, select=1. Next state WB.
  - LOAD (0000011, f3=010 only): alu_op=000000, select=1. Next state MEM.
  - STORE (0100011, f3=010 only): alu_op=000000, select=1. Next state MEM.
  - BRANCH (1100011): branch=1, select=0.
    - alu_op=100001 for f3 00x, 001000 for f3 10x, 001100 for f3 11x.
    - f3 01x -> illegal, HALT.
    - pc_write=1 with pc_taken=pc_select sampled this cycle. Next state FETCH.
  - LOAD/STORE with f3 != 010 -> illegal, HALT.
- MEM:
  - Hold mem_read (load) or mem_write (store) high until mem_ready, inclusive.
  - Store: on mem_ready, pc_write=1 with pc_taken=0, then FETCH.
  - Load: on mem_ready, go to WB.
- WB:
  - reg_write=1 for exactly one cycle, suppressed when rd==0.
  - wb_from_mem=1 for loads.
  - pc_write=1 with pc_taken=0; then FETCH.
- Latency with zero-wait memories:
  - ALU ops: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Strobe rules:
  - pc_write fires exactly once per retired instruction and never in HALT.
  - reg_write and mem strobes never overlap.
- Inputs outside their state are ignored: instr_valid outside FETCH, mem_ready outside MEM, pc_select outside branch EXECUTE.

Test Plan:
- Reset then instr 0x002081B3 (add x3,x1,x2), instr_valid held -> EXECUTE alu_op=000001, select=0. WB reg_write=1 with rd=3, pc_write=1, pc_taken=0. Cycle 5 back in FETCH.
- instr 0x40F55513 (srai x10,x10,15) -> alu_op=110100, select=1, imm=0x40F (low 12 bits), rd=10.
- bne 0xFE209EE3 with pc_select=1 -> branch=1, funct3=001, alu_op=100001, imm=0xFFFFFFFC. pc_write=1 and pc_taken=1 in EXECUTE; no reg_write.
- lw 0x0040A183 with mem_ready delayed 3 cycles -> mem_read high for 4 cycles. Then WB with wb_from_mem=1 and reg_write=1.
- Opcode 0x0000007F -> illegal=1, HALT. No strobes and instr_req=0 for 20 cycles; reset then returns to FETCH with illegal=0.
- Reset asserted during MEM of a store -> next cycle mem_write=0, state FETCH, no pc_write.
